// File: rtl/inv_cipher_iter.sv
// Iterative AES inverse cipher: one FIPS-197 InvCipher round per clock over a 128-bit state.
// Round keys are read combinationally from an external key-schedule store through rk_idx/rk.
module inv_cipher_iter #(
   parameter int NR    = 10,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     ciphertext,
   output logic [IDX_W-1:0] rk_idx,
   input  logic [127:0]     rk,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     plaintext,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);

   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Constant multiply: k selects which of a, 2a, 4a, 8a are summed.
   function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
      logic [7:0] a2, a4, a8;
      a2 = xt(a);
      a4 = xt(a2);
      a8 = xt(a4);
      return (k[3] ? a8 : 8'h00) ^ (k[2] ? a4 : 8'h00) ^
             (k[1] ? a2 : 8'h00) ^ (k[0] ? a  : 8'h00);
   endfunction

   // Byte k = r + 4c sits at [127-8k -: 8]; row r rotates right by r columns.
   function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = INV_SBOX[s[127-8*(4*((c-r+4)%4)+r) -: 8]];
      return o;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 32] = {
            gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
            gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
            gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
            gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
      end
      return o;
   endfunction

   fsm_e             fsm_q, fsm_d;
   logic [127:0]     st_q, st_d;
   logic [127:0]     pt_q, pt_d;
   logic [IDX_W-1:0] rnd_q, rnd_d;
   logic [127:0]     sub_ark;

   assign sub_ark   = inv_shift_sub(st_q) ^ rk;
   assign plaintext = pt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q <= IDLE;
         st_q  <= '0;
         pt_q  <= '0;
         rnd_q <= '0;
      end else begin
         fsm_q <= fsm_d;
         st_q  <= st_d;
         pt_q  <= pt_d;
         rnd_q <= rnd_d;
      end
   end

   always_comb begin
      fsm_d     = fsm_q;
      st_d      = st_q;
      pt_d      = pt_q;
      rnd_d     = rnd_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      rk_idx    = LAST_IDX;
      case (fsm_q)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               st_d  = ciphertext ^ rk;
               rnd_d = IDX_W'(NR - 1);
               fsm_d = ROUND;
            end
         end
         ROUND: begin
            rk_idx = rnd_q;
            // The final round skips InvMixColumns and lands straight in the output register.
            if (rnd_q != '0) begin
               st_d  = inv_mix(sub_ark);
               rnd_d = rnd_q - 1'b1;
            end else begin
               pt_d  = sub_ark;
               fsm_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_inv_cipher_iter.sv
// Bench for inv_cipher_iter: byte-level AES reference model with its own key schedule,
// per-cycle comparison of the DUT handshake/outputs, and FIPS-197 known-answer vectors.
module tb_inv_cipher_iter;
   localparam int NR    = 10;
   localparam int IDX_W = 4;

   localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [127:0]     ciphertext = '0;
   logic [IDX_W-1:0] rk_idx;
   logic [127:0]     rk;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [127:0]     plaintext;
   logic             busy;

   always #5 clk = ~clk;

   inv_cipher_iter #(.NR(NR), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .ciphertext(ciphertext), .rk_idx(rk_idx), .rk(rk), .out_valid(out_valid),
      .out_ready(out_ready), .plaintext(plaintext), .busy(busy));

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   logic [7:0]   sbox  [256];
   logic [7:0]   isbox [256];
   logic [127:0] rkeys [0:NR];

   assign rk = (int'(rk_idx) <= NR) ? rkeys[rk_idx] : '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   // S-box derived from first principles: GF(2^8) inverse followed by the affine map.
   task automatic init_tables();
      logic [7:0] inv, s;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
         sbox[a]  = s;
         isbox[s] = 8'(a);
      end
   endtask

   task automatic set_key(input logic [127:0] k);
      logic [31:0] w [0:4*NR+3];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 4*(NR+1); i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rcon, 24'h0};
            rcon = gmul(rcon, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= NR; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Reference InvCipher on a 4x4 byte grid using the currently loaded key schedule.
   function automatic logic [127:0] aes_dec(input logic [127:0] ct);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   m [4];
      logic [7:0]   acc;
      logic [127:0] o;
      m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
      for (int k = 0; k < 16; k++) s[k] = ct[127-8*k -: 8] ^ rkeys[NR][127-8*k -: 8];
      for (int rnd = NR - 1; rnd >= 0; rnd--) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               t[r+4*c] = isbox[s[r+4*((c-r+4)%4)]];
         for (int k = 0; k < 16; k++) t[k] = t[k] ^ rkeys[rnd][127-8*k -: 8];
         if (rnd > 0) begin
            for (int c = 0; c < 4; c++)
               for (int i = 0; i < 4; i++) begin
                  acc = 8'h00;
                  for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[(j-i+4)%4], t[j+4*c]);
                  s[i+4*c] = acc;
               end
         end else begin
            for (int k = 0; k < 16; k++) s[k] = t[k];
         end
      end
      o = '0;
      for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
      return o;
   endfunction

   // Transaction-level model: 0 = waiting for input, 1 = rounds remaining m_cnt, 2 = result held.
   int           m_state = 0;
   int           m_cnt = 0;
   logic [127:0] m_exp = '0;
   logic [127:0] m_pt = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_state <= 0;
         m_cnt   <= 0;
         m_pt    <= '0;
      end else begin
         case (m_state)
            0: if (in_valid) begin
                  m_exp   <= aes_dec(ciphertext);
                  m_cnt   <= NR;
                  m_state <= 1;
               end
            1: if (m_cnt == 1) begin
                  m_pt    <= m_exp;
                  m_cnt   <= 0;
                  m_state <= 2;
               end else m_cnt <= m_cnt - 1;
            2: if (out_ready) m_state <= 0;
            default: m_state <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("out_valid", 128'(out_valid), 128'(m_state == 2));
         chk("in_ready", 128'(in_ready), 128'(m_state == 0));
         chk("busy", 128'(busy), 128'(m_state != 0));
         chk("plaintext", plaintext, m_pt);
         if (m_state == 0) chk("rk_idx_idle", 128'(rk_idx), 128'(NR));
         else if (m_state == 1) chk("rk_idx_round", 128'(rk_idx), 128'(m_cnt - 1));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_out(input string name);
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
         step();
         n++;
      end
      if (!out_valid) chk({name, "_timeout"}, 128'(out_valid), 128'(1));
   endtask

   // Accept one block, check latency/result, hold out_ready low for `hold` cycles, then release.
   task automatic run_block(input string name, input logic [127:0] ct, input logic [127:0] key,
                            input int hold, input logic [127:0] exp_pt);
      int acc;
      set_key(key);
      ciphertext = ct;
      out_ready  = (hold == 0);
      in_valid   = 1'b1;
      chk({name, "_idx_accept"}, 128'(rk_idx), 128'(NR));
      acc = cyc;
      step();
      in_valid = 1'b0;
      chk({name, "_idx_first"}, 128'(rk_idx), 128'(NR - 1));
      wait_out(name);
      chk({name, "_latency"}, 128'(cyc - acc), 128'(NR + 1));
      chk({name, "_pt"}, plaintext, exp_pt);
      for (int i = 0; i < hold; i++) begin
         step();
         chk({name, "_hold_valid"}, 128'(out_valid), 128'(1));
         chk({name, "_hold_pt"}, plaintext, exp_pt);
      end
      out_ready = 1'b1;
      step();
      chk({name, "_back_idle"}, 128'({out_valid, in_ready}), 128'(2'b01));
   endtask

   initial begin
      logic [127:0] cts [3];
      logic [127:0] keys [3];
      logic [127:0] pts [3];
      logic [127:0] rct;
      int           t_out [3];

      init_tables();
      chk("model_sbox00", 128'(sbox[0]), 128'h63);
      chk("model_isbox00", 128'(isbox[0]), 128'h52);
      set_key(K2);
      chk("model_rk10_k2", rkeys[NR], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      chk("model_dec_k2", aes_dec(CT2), PT2);
      set_key(K1);
      chk("model_rk10_k1", rkeys[NR], 128'h13111d7fe3944a17f307a78b4d2b30c5);
      chk("model_dec_k1", aes_dec(CT1), PT1);

      // Reset state
      step();
      step();
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_pt", plaintext, 128'h0);
      chk("rst_rk_idx", 128'(rk_idx), 128'(NR));
      rst = 1'b0;
      chk_en = 1'b1;
      step();

      // T1 / T3: known answer, latency and index walk
      run_block("t1", CT1, K1, 0, PT1);
      // T2: backpressure
      run_block("t2", CT2, K2, 5, PT2);

      // T4: in_valid pulsed with junk during ROUND and DONE
      set_key(K1);
      ciphertext = CT1;
      out_ready  = 1'b0;
      in_valid   = 1'b1;
      step();
      for (int i = 0; i < 14; i++) begin
         ciphertext = {$urandom, $urandom, $urandom, $urandom};
         in_valid   = i[0];
         step();
      end
      in_valid = 1'b0;
      chk("t4_valid", 128'(out_valid), 128'(1));
      chk("t4_pt", plaintext, PT1);
      out_ready = 1'b1;
      step();
      rct = {$urandom, $urandom, $urandom, $urandom};
      ciphertext = rct;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_out("t4_next");
      chk("t4_next_pt", plaintext, aes_dec(rct));
      step();

      // T5: asynchronous reset in the middle of the rounds
      set_key(K1);
      ciphertext = CT1;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      rst = 1'b1;
      #1;
      chk("t5_out_valid", 128'(out_valid), 128'(0));
      chk("t5_pt", plaintext, 128'h0);
      chk("t5_in_ready", 128'(in_ready), 128'(1));
      chk("t5_busy", 128'(busy), 128'(0));
      chk("t5_rk_idx", 128'(rk_idx), 128'(NR));
      step();
      step();
      rst = 1'b0;
      step();
      run_block("t5_rerun", CT1, K1, 0, PT1);

      // T6: back-to-back with in_valid and out_ready held high
      cts[0] = CT1; keys[0] = K1; pts[0] = PT1;
      cts[1] = CT2; keys[1] = K2; pts[1] = PT2;
      cts[2] = CT1; keys[2] = K1; pts[2] = PT1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         int n;
         n = 0;
         while (!in_ready && n < 40) begin
            step();
            n++;
         end
         set_key(keys[i]);
         ciphertext = cts[i];
         step();
         wait_out("t6");
         t_out[i] = cyc;
         chk("t6_pt", plaintext, pts[i]);
         if (i > 0) chk("t6_gap", 128'(t_out[i] - t_out[i-1]), 128'(NR + 2));
      end
      in_valid = 1'b0;
      step();
      step();

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired actual=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
